// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream to 32-bit imem words, holds core in reset while loading
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W     = 6,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CSUM, S_HOLD, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_HOLD, S_RUN} state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rx_ready_q, imem_we_q, core_reset_q, busy_q, done_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              start_ok, hs, last_word;
    logic [ADDR_W:0]   num_clamped;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              error_q;
`endif

    // Any count with the top bit set is at least full capacity.
    assign num_clamped = num_words[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : num_words;
    assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_RUN)
`ifdef LOADER_CHECKSUM_EN
                                   || (state_q == S_ERR)
`endif
                                   );
    assign hs          = rx_valid && rx_ready_q;
    assign last_word   = (({1'b0, idx_q} + (ADDR_W+1)'(1)) == num_q);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        idx_d      = idx_q;
        num_d      = num_q;
        hold_d     = hold_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (start_ok) begin
            byte_cnt_d = 2'd0;
            word_d     = 32'd0;
            idx_d      = '0;
            hold_d     = '0;
            num_d      = num_clamped;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = 8'd0;
`endif
            state_d    = (num_clamped == '0) ? S_HOLD : S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (hs) begin
                        word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = csum_q + rx_data;
`endif
                        if (byte_cnt_q == 2'd3) state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_HOLD;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (hs) state_d = (rx_data == csum_q) ? S_HOLD : S_ERR;
                end
`endif
                S_HOLD: begin
                    if (hold_q == HOLD_W'(RESET_HOLD - 1)) state_d = S_RUN;
                    else                                    hold_d  = hold_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            word_q       <= 32'd0;
            idx_q        <= '0;
            num_q        <= '0;
            hold_q       <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            hold_q       <= hold_d;
            imem_we_q    <= (state_d == S_WRITE);
            if (state_d == S_WRITE) begin
                imem_addr_q  <= idx_q;
                imem_wdata_q <= word_d;
            end
            core_reset_q <= (state_d != S_RUN);
            done_q       <= (state_d == S_RUN);
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
            error_q      <= (state_d == S_ERR);
            rx_ready_q   <= (state_d == S_LOAD) || (state_d == S_CSUM);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_WRITE) ||
                            (state_d == S_CSUM) || (state_d == S_HOLD);
`else
            rx_ready_q   <= (state_d == S_LOAD);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_WRITE) ||
                            (state_d == S_HOLD);
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int RH     = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam int CSX = 1;
`else
    localparam int CSX = 0;
`endif

    logic              clk, reset, start, rx_valid, rx_ready, imem_we;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset, busy, done, error;

    imem_loader #(.ADDR_W(ADDR_W), .RESET_HOLD(RH)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0, failures = 0, t0 = 0;
    int          done_cyc;
    bit          timed_out;
    logic        snap_cr, snap_done, snap_err;
    int          wr_addr[$], wr_cyc[$], acc3_cyc[$];
    logic [31:0] wr_data[$], exp_words[$];
    logic [7:0]  tx_q[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc - t0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; num_words = '0;
        tick; tick;
        reset = 1'b0;
    endtask

    // Turns exp_words into the byte stream, plus the trailing checksum (xored to corrupt).
    task automatic prep(input logic [7:0] cs_xor);
        logic [7:0] sum;
        sum = 8'd0;
        tx_q.delete();
        foreach (exp_words[i]) begin
            for (int b = 0; b < 4; b++) begin
                tx_q.push_back(exp_words[i][8*b +: 8]);
                sum = sum + exp_words[i][8*b +: 8];
            end
        end
        if (CSX != 0 && exp_words.size() > 0) tx_q.push_back(sum ^ cs_xor);
    endtask

    task automatic load(input int nw, input bit gaps, input int budget);
        int bc;
        bc = 0; timed_out = 0; done_cyc = -1;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc3_cyc.delete();
        num_words = (ADDR_W+1)'(nw); start = 1'b1; t0 = cyc;
        tick;
        start = 1'b0;
        snap_cr = core_reset; snap_done = done; snap_err = error;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1 || error === 1'b1) begin
                done_cyc = cyc - t0;
                break;
            end
            rx_valid = (tx_q.size() > 0) && (!gaps || ((cyc - t0) % 2 == 1));
            rx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
            if (rx_valid && rx_ready === 1'b1) begin
                void'(tx_q.pop_front());
                bc++;
                if (bc % 4 == 0) acc3_cyc.push_back(cyc - t0);
            end
            tick;
        end
        rx_valid = 1'b0;
        if (done_cyc < 0) timed_out = 1;
    endtask

    task automatic test_reset;
        do_reset;
        checks += 8;
        if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_imem_we got=%b exp=0", imem_we); end
        if (imem_addr !== '0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
        if (imem_wdata !== 32'd0) begin failures++; $display("FAIL reset_imem_wdata got=%h exp=0", imem_wdata); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    endtask

    task automatic test_single;
        exp_words = '{32'hE0855004};
        prep(8'h00);
        load(1, 0, 500);
        checks += 6;
        if (timed_out) begin failures++; $display("FAIL single_timeout got=none exp=done"); end
        if (wr_addr.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", wr_addr.size()); end
        else begin
            if (wr_addr[0] != 0) begin failures++; $display("FAIL single_addr got=%0d exp=0", wr_addr[0]); end
            if (wr_data[0] !== 32'hE0855004) begin failures++; $display("FAIL single_data got=%h exp=E0855004", wr_data[0]); end
            if (wr_cyc[0] != 5) begin failures++; $display("FAIL single_we_cycle got=%0d exp=5", wr_cyc[0]); end
        end
        if (done_cyc != 6 + CSX + RH || core_reset !== 1'b0) begin
            failures++; $display("FAIL single_release got=%0d/%b exp=%0d/0", done_cyc, core_reset, 6 + CSX + RH);
        end
    endtask

    task automatic test_gaps;
        exp_words = '{32'hE0855004, 32'hE2800001};
        prep(8'h00);
        load(2, 1, 500);
        checks += 2;
        if (timed_out) begin failures++; $display("FAIL gaps_timeout got=none exp=done"); end
        if (wr_addr.size() != 2 || acc3_cyc.size() != 2) begin
            failures++; $display("FAIL gaps_count got=%0d exp=2", wr_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wr_addr[i] != i || wr_data[i] !== exp_words[i] || wr_cyc[i] != acc3_cyc[i] + 1) begin
                    failures++;
                    $display("FAIL gaps_write%0d got=%0d/%h@%0d exp=%0d/%h@%0d", i, wr_addr[i], wr_data[i],
                             wr_cyc[i], i, exp_words[i], acc3_cyc[i] + 1);
                end
            end
        end
    endtask

    task automatic test_zero;
        exp_words.delete();
        prep(8'h00);
        load(0, 0, 100);
        checks += 2;
        if (wr_addr.size() != 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wr_addr.size()); end
        if (done_cyc != 1 + RH || core_reset !== 1'b0) begin
            failures++; $display("FAIL zero_release got=%0d/%b exp=%0d/0", done_cyc, core_reset, 1 + RH);
        end
    endtask

    task automatic test_ignore_and_abort;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        num_words = 7'd1; start = 1'b1; t0 = cyc;
        tick;
        start = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h04; tick;
        rx_data = 8'h50; tick;
        rx_valid = 1'b0; num_words = 7'd0; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            failures++; $display("FAIL start_in_load got=busy%b/rdy%b exp=busy1/rdy1", busy, rx_ready);
        end
        tick; tick;
        reset = 1'b1; tick; reset = 1'b0;
        checks += 2;
        if (core_reset !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_state got=cr%b/busy%b/rdy%b/done%b exp=cr1/busy0/rdy0/done0",
                                 core_reset, busy, rx_ready, done);
        end
        if (wr_addr.size() != 0) begin failures++; $display("FAIL abort_writes got=%0d exp=0", wr_addr.size()); end
        exp_words = '{32'hE2800001};
        prep(8'h00);
        load(1, 0, 500);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== 32'hE2800001 || done !== 1'b1) begin
            failures++; $display("FAIL abort_reload got=%0d writes done=%b exp=1 write done=1", wr_addr.size(), done);
        end
    endtask

    task automatic test_clamp;
        exp_words.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) exp_words.push_back($urandom);
        prep(8'h00);
        load((1 << (ADDR_W + 1)) - 1, 0, 2000);
        checks += 2;
        if (wr_addr.size() != (1 << ADDR_W)) begin
            failures++; $display("FAIL clamp_count got=%0d exp=%0d", wr_addr.size(), 1 << ADDR_W);
        end else begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                checks++;
                if (wr_addr[i] != i || wr_data[i] !== exp_words[i]) begin
                    failures++; $display("FAIL clamp_write%0d got=%0d/%h exp=%0d/%h", i, wr_addr[i], wr_data[i], i, exp_words[i]);
                end
            end
        end
        if (done_cyc != 5 * (1 << ADDR_W) + 1 + CSX + RH) begin
            failures++; $display("FAIL clamp_release got=%0d exp=%0d", done_cyc, 5 * (1 << ADDR_W) + 1 + CSX + RH);
        end
    endtask

    task automatic test_random;
        int n;
        bit g;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 6);
            g = bit'($urandom_range(0, 1));
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back($urandom);
            prep(8'h00);
            load(n, g, 1000);
            checks += 2;
            if (timed_out || done !== 1'b1) begin failures++; $display("FAIL rand%0d_done got=%b exp=1", it, done); end
            if (wr_addr.size() != n) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, wr_addr.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wr_addr[i] != i || wr_data[i] !== exp_words[i]) begin
                        failures++; $display("FAIL rand%0d_write%0d got=%0d/%h exp=%0d/%h", it, i, wr_addr[i], wr_data[i], i, exp_words[i]);
                    end
                end
                if (!g) begin
                    checks++;
                    if (wr_cyc[n-1] != 5 * n || done_cyc != 5 * n + 1 + CSX + RH) begin
                        failures++; $display("FAIL rand%0d_timing got=%0d/%0d exp=%0d/%0d", it, wr_cyc[n-1], done_cyc,
                                             5 * n, 5 * n + 1 + CSX + RH);
                    end
                end
            end
        end
    endtask

    task automatic test_reload_from_run;
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL run_done_sticky got=%b exp=1", done); end
        exp_words = '{32'hE0855004};
        prep(8'h00);
        load(1, 0, 500);
        checks += 2;
        if (snap_cr !== 1'b1 || snap_done !== 1'b0) begin
            failures++; $display("FAIL reload_start got=cr%b/done%b exp=cr1/done0", snap_cr, snap_done);
        end
        if (wr_cyc.size() != 1 || wr_cyc[0] != 5 || wr_data[0] !== 32'hE0855004 || done_cyc != 6 + CSX + RH) begin
            failures++; $display("FAIL reload_timing got=%0d writes done@%0d exp=1 write done@%0d", wr_cyc.size(), done_cyc, 6 + CSX + RH);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        exp_words = '{32'hE0855004};
        prep(8'h00);
        checks++;
        if (tx_q[4] !== 8'hB9 ) begin failures++; $display("FAIL csum_model got=%h exp=B9", tx_q[4]); end
        load(1, 0, 500);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL csum_good got=done%b/err%b exp=done1/err0", done, error); end
        prep(8'hB9);
        load(1, 0, 500);
        tick; tick; tick; tick; tick; tick;
        checks++;
        if (error !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL csum_bad got=err%b/cr%b/done%b/busy%b exp=err1/cr1/done0/busy0", error, core_reset, done, busy);
        end
        exp_words.delete();
        prep(8'h00);
        load(0, 0, 100);
        checks++;
        if (snap_err !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL csum_clear got=err%b/done%b exp=err0/done1", snap_err, done); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_gaps;
        test_zero;
        test_ignore_and_abort;
        test_clamp;
        test_random;
        test_reload_from_run;
`ifdef LOADER_CHECKSUM_EN
        test_checksum;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
